// File: rtl/ahb_decoder_pipelined.sv
// ahb_decoder_pipelined: AHB address decoder with remap, registered data-phase select, ERROR default slave and decode-error diagnostics
module ahb_decoder_pipelined #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int SLAVE_NUM = 4,
  parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_LOW = {32'h3000, 32'h2000, 32'h1000, 32'h0000},
  parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_HIGH = {32'h3FFF, 32'h2FFF, 32'h1FFF, 32'h0FFF},
  parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_LOW_RMP = {32'h3000, 32'h2000, 32'h0000, 32'h1000},
  parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_HIGH_RMP = {32'h3FFF, 32'h2FFF, 32'h0FFF, 32'h1FFF},
  parameter int ERR_CNT_W = 8
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                htrans,
  input  logic                      hready,
  input  logic                      hremap,
  output logic [SLAVE_NUM-1:0]      hreq,
  output logic                      default_slv_sel,
  output logic [SLAVE_NUM-1:0]      hsel_dp,
  output logic                      def_dp,
  output logic                      def_hready,
  output logic [1:0]                def_hresp,
  output logic [ERR_CNT_W-1:0]      dec_err_cnt,
  output logic [AHB_ADDR_WIDTH-1:0] dec_err_addr
);
  localparam int AW = AHB_ADDR_WIDTH;
  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;
  state_t state, next;
  logic [SLAVE_NUM-1:0] hit;
  logic active, acc_err;
  // descending scan so the lowest matching index is the last one written
  always_comb begin
    hit = '0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--)
      if ((hremap ? SLV_LOW_RMP[i*AW +: AW] : SLV_LOW[i*AW +: AW]) <= haddr &&
          haddr <= (hremap ? SLV_HIGH_RMP[i*AW +: AW] : SLV_HIGH[i*AW +: AW])) begin
        hit = '0;
        hit[i] = 1'b1;
      end
  end
  assign active = htrans[1];
  assign hreq = active ? hit : '0;
  assign default_slv_sel = active && hit == '0;
  assign acc_err = hready && default_slv_sel;
  always_comb begin
    next = state == S_ERR1 ? S_ERR2 : (acc_err ? S_ERR1 : S_IDLE);
    def_hready = state != S_ERR1;
    def_hresp = state == S_IDLE ? 2'b00 : 2'b01;
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= S_IDLE;
      hsel_dp <= '0;
      def_dp <= 1'b0;
      dec_err_cnt <= '0;
      dec_err_addr <= '0;
    end else begin
      state <= next;
      if (hready) begin
        hsel_dp <= hreq;
        def_dp <= default_slv_sel;
      end
      if (acc_err) begin
        if (!(&dec_err_cnt)) dec_err_cnt <= dec_err_cnt + ERR_CNT_W'(1);
        dec_err_addr <= haddr;
      end
    end
  end
endmodule
